// File: rtl/mux_uart.sv
`default_nettype none
// ============================================================================
// mux_uart : CPU6 bus-mapped 8N1 serial port (status BASE_ADDR, data +1)
// Revision : 1.0
// ============================================================================
module mux_uart #(
    parameter logic [15:0] BASE_ADDR = 16'hF200,
    parameter int          DIVISOR   = 104,
    parameter int          TX_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sel,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam int          PTR_W     = $clog2(TX_DEPTH);
    localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] DIV_M1    = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF_M1   = 16'(DIVISOR / 2 - 1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(TX_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        TXS_IDLE  = 2'd0,
        TXS_START = 2'd1,
        TXS_DATA  = 2'd2,
        TXS_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RXS_IDLE  = 2'd0,
        RXS_START = 2'd1,
        RXS_DATA  = 2'd2,
        RXS_STOP  = 2'd3
    } rx_state_e;

    // Bus decode
    logic sel_stat, sel_data, wr_data, rd_data, rd_stat;

    // TX FIFO
    logic [7:0]       fifo_mem_q [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fifo_cnt_q, fifo_cnt_d;
    logic             fifo_full, fifo_empty, push, pop;

    // Transmitter
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        tx_bit_end;

    // Receiver
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_brk_q, rx_brk_d;
    logic        rx_bit_end, rx_done_ok, fe_set;

    // Status / holding registers
    logic       rx_rdy_q, rx_rdy_d, fe_q, fe_d, or_q, or_d;
    logic [7:0] rx_hold_q, rx_hold_d;
    logic [7:0] status;

    always_comb begin
        sel_stat = (address == BASE_ADDR);
        sel_data = (address == DATA_ADDR);
        wr_data  = write_en && sel_data;
        rd_data  = read_en && sel_data;
        rd_stat  = read_en && sel_stat;
    end

    assign fifo_full  = (fifo_cnt_q == DEPTH_C);
    assign fifo_empty = (fifo_cnt_q == '0);
    // A write into a full FIFO is still accepted when the transmitter frees a slot on the same edge
    assign push       = wr_data && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem_q[wr_ptr_q] <= data_in;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop        = 1'b0;
        tx_bit_end = (tx_cnt_q == DIV_M1);
        case (tx_state_q)
            TXS_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_mem_q[rd_ptr_q];
                    tx_cnt_d   = '0;
                    tx_state_d = TXS_START;
                end
            end
            TXS_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TXS_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TXS_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = TXS_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TXS_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    // Queued bytes follow immediately, with no idle bit between frames
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_shift_d = fifo_mem_q[rd_ptr_q];
                        tx_state_d = TXS_START;
                    end else begin
                        tx_state_d = TXS_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TXS_IDLE;
        endcase

        case (tx_state_q)
            TXS_START: tx_d = 1'b0;
            TXS_DATA:  tx_d = tx_shift_q[0];
            default:   tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_brk_d   = rx_brk_q;
        rx_done_ok = 1'b0;
        fe_set     = 1'b0;
        rx_bit_end = (rx_cnt_q == DIV_M1);
        case (rx_state_q)
            RXS_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RXS_START;
                end
            end
            RXS_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RXS_IDLE;
                    end else begin
                        rx_bit_d   = '0;
                        rx_state_d = RXS_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RXS_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RXS_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RXS_STOP: begin
                // After a bad stop bit, hold here until the line returns high
                if (rx_brk_q) begin
                    if (rx_sync_q) begin
                        rx_brk_d   = 1'b0;
                        rx_state_d = RXS_IDLE;
                    end
                end else if (rx_bit_end) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_done_ok = 1'b1;
                        rx_state_d = RXS_IDLE;
                    end else begin
                        fe_set   = 1'b1;
                        rx_brk_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RXS_IDLE;
        endcase
    end

    always_comb begin
        rx_rdy_d  = rx_rdy_q;
        rx_hold_d = rx_hold_q;
        fe_d      = fe_q;
        or_d      = or_q;
        if (rd_stat) begin
            fe_d = 1'b0;
            or_d = 1'b0;
        end
        if (rd_data) rx_rdy_d = 1'b0;
        if (fe_set)  fe_d = 1'b1;
        // A read of the data register on the completion edge makes room for the new byte
        if (rx_done_ok) begin
            if (!rx_rdy_q || rd_data) begin
                rx_hold_d = rx_shift_q;
                rx_rdy_d  = 1'b1;
            end else begin
                or_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            tx_state_q <= TXS_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RXS_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_brk_q   <= 1'b0;
            rx_rdy_q   <= 1'b0;
            rx_hold_q  <= '0;
            fe_q       <= 1'b0;
            or_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_brk_q   <= rx_brk_d;
            rx_rdy_q   <= rx_rdy_d;
            rx_hold_q  <= rx_hold_d;
            fe_q       <= fe_d;
            or_q       <= or_d;
        end
    end

    always_comb begin
        status = {3'b000, or_q, fe_q,
                  (fifo_empty && (tx_state_q == TXS_IDLE)), !fifo_full, rx_rdy_q};
        data_out = 8'h00;
        if (sel_stat)      data_out = status;
        else if (sel_data) data_out = rx_hold_q;
    end

    assign sel = sel_stat || sel_data;
    assign tx  = tx_q;
    assign irq = rx_rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_uart.sv
`default_nettype none
// ============================================================================
// tb_mux_uart : self-checking bench for mux_uart with a frame-level model
// Revision : 1.0
// ============================================================================
module tb_mux_uart;

    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] STAT  = 16'hF200;
    localparam logic [15:0] DATA  = 16'hF201;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] address  = STAT;
    logic        write_en = 1'b0;
    logic        read_en  = 1'b0;
    logic [7:0]  data_in  = 8'h00;
    logic [7:0]  data_out;
    logic        sel;
    logic        rx       = 1'b1;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Receive-side reference state
    bit         m_rdy = 1'b0;
    bit         m_fe  = 1'b0;
    bit         m_or  = 1'b0;
    logic [7:0] m_hold = 8'h00;

    mux_uart #(
        .BASE_ADDR (16'hF200),
        .DIVISOR   (DIV),
        .TX_DEPTH  (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .data_out (data_out),
        .sel      (sel),
        .rx       (rx),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] exp_status(input bit tx_rdy, input bit tx_idle);
        return {3'b000, m_or, m_fe, tx_idle, tx_rdy, m_rdy};
    endfunction

    // Line level of position p (0 start, 1..8 data LSB first, 9 stop) of an 8N1 frame
    function automatic bit frame_bit(input logic [7:0] b, input int p);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    task automatic model_rx(input logic [7:0] b, input bit stop);
        if (!stop)       m_fe = 1'b1;
        else if (!m_rdy) begin m_hold = b; m_rdy = 1'b1; end
        else             m_or = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        for (int p = 0; p < 10; p++) begin
            rx = (p == 9) ? stop : frame_bit(b, p);
            repeat (DIV) tick();
        end
        rx = 1'b1;
        repeat (6) tick();
        model_rx(b, stop);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        tick();
        address = STAT;
        #1;
        n_checks++;
        if (data_out !== 8'h06) begin n_fail++; $display("FAIL reset_status: got %h expected 06", data_out); end
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_checks++;
        if (sel !== 1'b1) begin n_fail++; $display("FAIL sel_status: got %b expected 1", sel); end
        address = 16'hF100;
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL unmapped_data: got %h expected 00", data_out); end
        n_checks++;
        if (sel !== 1'b0) begin n_fail++; $display("FAIL unmapped_sel: got %b expected 0", sel); end
        address = STAT;
    endtask

    task automatic test_tx_frame(input logic [7:0] b);
        bit exp_tx;
        address  = DATA;
        data_in  = b;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        address  = STAT;
        #1;
        n_checks++;
        if (data_out !== exp_status(1'b1, 1'b0))
            begin n_fail++; $display("FAIL tx_busy_status %h: got %h expected %h", b, data_out, exp_status(1'b1, 1'b0)); end
        tick();
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_latency %h: tx=%b expected 1", b, tx); end
        for (int i = 0; i < 10 * DIV; i++) begin
            tick();
            exp_tx = frame_bit(b, i / DIV);
            n_checks++;
            if (tx !== exp_tx)
                begin n_fail++; $display("FAIL tx_bit %h cycle %0d: tx=%b expected %b", b, i, tx, exp_tx); end
        end
        n_checks++;
        if (data_out !== exp_status(1'b1, 1'b1))
            begin n_fail++; $display("FAIL tx_done_status %h: got %h expected %h", b, data_out, exp_status(1'b1, 1'b1)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        bit         exp_tx;
        int         bi;
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int n = 1; n <= 215; n++) begin
            if (n == 6 || n == 7) begin
                address  = STAT;
                write_en = 1'b0;
                #1;
                n_checks++;
                if (data_out !== exp_status(1'b0, 1'b0))
                    begin n_fail++; $display("FAIL fifo_full_status n=%0d: got %h expected %h", n, data_out, exp_status(1'b0, 1'b0)); end
            end
            if (n <= 6) begin
                address  = DATA;
                data_in  = bytes[n-1];
                write_en = 1'b1;
            end else begin
                address  = STAT;
                write_en = 1'b0;
            end
            tick();
            exp_tx = 1'b1;
            if (n >= 3 && n < 3 + 50 * DIV) begin
                bi     = (n - 3) / DIV;
                exp_tx = frame_bit(bytes[bi / 10], bi % 10);
            end
            n_checks++;
            if (tx !== exp_tx)
                begin n_fail++; $display("FAIL b2b_tx cycle %0d: tx=%b expected %b", n, tx, exp_tx); end
        end
        n_checks++;
        if (data_out !== exp_status(1'b1, 1'b1))
            begin n_fail++; $display("FAIL b2b_done_status: got %h expected %h", data_out, exp_status(1'b1, 1'b1)); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] b;
        send_rx(8'hA5, 1'b1);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_irq: got %b expected 1", irq); end
        address = DATA;
        read_en = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL rx_a5_data: got %h expected a5", data_out); end
        tick();
        read_en = 1'b0;
        m_rdy   = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
        n_checks++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL rx_hold_kept: got %h expected a5", data_out); end
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom_range(0, 255));
            send_rx(b, 1'b1);
            address = STAT;
            #1;
            n_checks++;
            if (data_out !== exp_status(1'b1, 1'b1))
                begin n_fail++; $display("FAIL rx_rand_status %h: got %h expected %h", b, data_out, exp_status(1'b1, 1'b1)); end
            address = DATA;
            read_en = 1'b1;
            #1;
            n_checks++;
            if (data_out !== m_hold)
                begin n_fail++; $display("FAIL rx_rand_data: got %h expected %h", data_out, m_hold); end
            tick();
            read_en = 1'b0;
            m_rdy   = 1'b0;
        end
    endtask

    task automatic test_overrun();
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        address = DATA;
        #1;
        n_checks++;
        if (data_out !== m_hold) begin n_fail++; $display("FAIL ovr_data: got %h expected %h", data_out, m_hold); end
        address = STAT;
        read_en = 1'b1;
        #1;
        n_checks++;
        if (data_out !== exp_status(1'b1, 1'b1))
            begin n_fail++; $display("FAIL ovr_status: got %h expected %h", data_out, exp_status(1'b1, 1'b1)); end
        tick();
        read_en = 1'b0;
        m_fe    = 1'b0;
        m_or    = 1'b0;
        n_checks++;
        if (data_out !== exp_status(1'b1, 1'b1))
            begin n_fail++; $display("FAIL ovr_cleared_status: got %h expected %h", data_out, exp_status(1'b1, 1'b1)); end
    endtask

    task automatic test_framing();
        logic [7:0] b;
        send_rx(8'h33, 1'b0);
        address = STAT;
        #1;
        n_checks++;
        if (data_out !== exp_status(1'b1, 1'b1))
            begin n_fail++; $display("FAIL fe_status: got %h expected %h", data_out, exp_status(1'b1, 1'b1)); end
        address = DATA;
        read_en = 1'b1;
        #1;
        n_checks++;
        if (data_out !== m_hold) begin n_fail++; $display("FAIL fe_hold: got %h expected %h", data_out, m_hold); end
        tick();
        m_rdy   = 1'b0;
        address = STAT;
        tick();
        m_fe    = 1'b0;
        read_en = 1'b0;
        // One-cycle low pulse must not start a byte
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (data_out !== exp_status(1'b1, 1'b1))
            begin n_fail++; $display("FAIL glitch_status: got %h expected %h", data_out, exp_status(1'b1, 1'b1)); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq: got %b expected 0", irq); end
        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b1);
        address = DATA;
        #1;
        n_checks++;
        if (data_out !== m_hold) begin n_fail++; $display("FAIL rx_after_glitch: got %h expected %h", data_out, m_hold); end
        address = STAT;
    endtask

    task automatic test_reset_mid_tx();
        for (int k = 0; k < 3; k++) begin
            address  = DATA;
            data_in  = 8'h00;
            write_en = 1'b1;
            tick();
        end
        write_en = 1'b0;
        address  = STAT;
        repeat (8) tick();
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_tx_low: tx=%b expected 0", tx); end
        #2 reset = 1'b0;
        m_rdy = 1'b0;
        m_fe  = 1'b0;
        m_or  = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: tx=%b expected 1", tx); end
        n_checks++;
        if (data_out !== 8'h06) begin n_fail++; $display("FAIL async_reset_status: got %h expected 06", data_out); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx cycle %0d: tx=%b expected 1", c, tx); end
        end
        n_checks++;
        if (data_out !== 8'h06) begin n_fail++; $display("FAIL post_reset_status: got %h expected 06", data_out); end
    endtask

    initial begin
        test_reset();
        test_tx_frame(8'h48);
        for (int k = 0; k < 3; k++) test_tx_frame(8'($urandom_range(0, 255)));
        test_back_to_back();
        test_rx_basic();
        test_overrun();
        test_framing();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
